// File: rtl/weight_tile_loader.sv
// weight_tile_loader: streams ARRAY_N-row weight tiles from the weight SRAM
// into the systolic array's weight registers, one row per cycle. It answers
// the controller's load request with the weights-preloaded flag w_ps. It
// pulses done after NUM_TILES tiles have been released by compute_done.
//
// Optional build macro WTL_PROTOCOL_CHECK_EN adds a sticky proto_err output.
// proto_err flags three events: compute_done outside HOLD, start while busy,
// and load_req held low in WAIT_REQ for more than 1024 consecutive cycles.
module weight_tile_loader #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ARRAY_N   = 8,
    parameter int unsigned NUM_TILES = 32,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                base_addr,
    input  logic                             load_req,
    input  logic                             compute_done,
    output logic                             mem_rd_en,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic [ARRAY_N*DATA_W-1:0]        mem_rdata,
    output logic [ARRAY_N*DATA_W-1:0]        w_data,
    output logic                             w_valid,
    output logic [$clog2(ARRAY_N)-1:0]       w_row,
    output logic                             w_ps,
    output logic [$clog2(NUM_TILES+1)-1:0]   tile_idx,
    output logic                             busy,
    output logic                             done
`ifdef WTL_PROTOCOL_CHECK_EN
    ,
    output logic                             proto_err
`endif
);

    localparam int unsigned ROW_W  = $clog2(ARRAY_N);
    localparam int unsigned TILE_W = $clog2(NUM_TILES + 1);
    localparam int unsigned ROW_DW = ARRAY_N * DATA_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REQ = 2'd1,
        FETCH    = 2'd2,
        HOLD     = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic [ROW_W-1:0]    rd_row_q, rd_row_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                w_valid_q, w_valid_d;
    logic [ROW_W-1:0]    w_row_q, w_row_d;
    logic                w_ps_q, w_ps_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                last_row;
    logic                last_tile;
    logic [ADDR_W-1:0]   tile_base;

    assign last_row  = (rd_row_q == ROW_W'(ARRAY_N - 1));
    assign last_tile = (tile_q == TILE_W'(NUM_TILES - 1));
    // First row of the current tile; wraps modulo 2^ADDR_W.
    assign tile_base = base_q + ADDR_W'(tile_q) * ADDR_W'(ARRAY_N);

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a fetch always runs to completion once started.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_REQ;
                end
            end
            WAIT_REQ: begin
                if (load_req) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (last_row) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (compute_done) begin
                    state_d = last_tile ? IDLE : WAIT_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; read data lands one cycle after each read.
    always_comb begin
        base_d      = base_q;
        tile_d      = tile_q;
        rd_row_d    = rd_row_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        w_valid_d   = mem_rd_en_q;
        w_row_d     = mem_rd_en_q ? rd_row_q : '0;
        w_ps_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d = base_addr;
                    tile_d = '0;
                    busy_d = 1'b1;
                end
            end
            WAIT_REQ: begin
                if (load_req) begin
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = tile_base;
                    rd_row_d    = '0;
                end
            end
            FETCH: begin
                if (!last_row) begin
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = mem_addr_q + ADDR_W'(1);
                    rd_row_d    = rd_row_q + ROW_W'(1);
                end
            end
            HOLD: begin
                if (compute_done) begin
                    tile_d = tile_q + TILE_W'(1);
                    if (last_tile) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end else begin
                    w_ps_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q      <= '0;
            tile_q      <= '0;
            rd_row_q    <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            w_valid_q   <= 1'b0;
            w_row_q     <= '0;
            w_ps_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            base_q      <= base_d;
            tile_q      <= tile_d;
            rd_row_q    <= rd_row_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            w_valid_q   <= w_valid_d;
            w_row_q     <= w_row_d;
            w_ps_q      <= w_ps_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign w_valid   = w_valid_q;
    assign w_row     = w_row_q;
    assign w_ps      = w_ps_q;
    assign tile_idx  = tile_q;
    assign busy      = busy_q;
    assign done      = done_q;
    // mem_rdata is already the SRAM's output register; the gate keeps
    // w_data at zero whenever no row is being delivered.
    assign w_data    = w_valid_q ? mem_rdata : ROW_DW'(0);

`ifdef WTL_PROTOCOL_CHECK_EN
    localparam int unsigned WD_W     = 11;
    localparam int unsigned WD_LIMIT = 1024;

    logic            proto_err_q, proto_err_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    // Sticky protocol-violation detector with a saturating WAIT_REQ watchdog.
    always_comb begin
        proto_err_d = proto_err_q;
        wd_cnt_d    = '0;
        if ((state_q == WAIT_REQ) && !load_req) begin
            if (wd_cnt_q == WD_W'(WD_LIMIT)) begin
                wd_cnt_d    = wd_cnt_q;
                proto_err_d = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
        end
        if (compute_done && (state_q != HOLD)) begin
            proto_err_d = 1'b1;
        end
        if (start && busy_q) begin
            proto_err_d = 1'b1;
        end
    end

    // Protocol checker registers; cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err_q <= 1'b0;
            wd_cnt_q    <= '0;
        end else begin
            proto_err_q <= proto_err_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_weight_tile_loader.sv
// Bench for weight_tile_loader: random SRAM contents and random tile timing,
// checked against address/data/timing expectations computed from the tile rules.
module tb_weight_tile_loader;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ARRAY_N   = 8;
    localparam int unsigned NUM_TILES = 32;
    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DW        = ARRAY_N * DATA_W;
    localparam int unsigned ROW_W     = $clog2(ARRAY_N);
    localparam int unsigned TILE_W    = $clog2(NUM_TILES + 1);
    localparam int unsigned DEPTH     = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              load_req;
    logic              compute_done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DW-1:0]     mem_rdata = '0;
    logic [DW-1:0]     w_data;
    logic              w_valid;
    logic [ROW_W-1:0]  w_row;
    logic              w_ps;
    logic [TILE_W-1:0] tile_idx;
    logic              busy;
    logic              done;
`ifdef WTL_PROTOCOL_CHECK_EN
    logic              proto_err;
`endif

    weight_tile_loader #(
        .DATA_W(DATA_W), .ARRAY_N(ARRAY_N), .NUM_TILES(NUM_TILES), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .load_req(load_req), .compute_done(compute_done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .w_data(w_data), .w_valid(w_valid), .w_row(w_row), .w_ps(w_ps),
        .tile_idx(tile_idx), .busy(busy), .done(done)
`ifdef WTL_PROTOCOL_CHECK_EN
        , .proto_err(proto_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0] cur_base;

    // Synchronous SRAM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // Event counters for w_ps rises and done pulses.
    int   ps_rises    = 0;
    int   done_pulses = 0;
    logic ps_prev     = 1'b0;
    always @(negedge clk) begin
        if (w_ps && !ps_prev) ps_rises++;
        ps_prev = w_ps;
        if (done) done_pulses++;
    end

    // Expected SRAM address of row r of tile k, modulo the address space.
    function automatic logic [ADDR_W-1:0] addr_of(input int k, input int r);
        int a;
        a = (int'(cur_base) + k * int'(ARRAY_N) + r) % int'(DEPTH);
        return ADDR_W'(a);
    endfunction

    task automatic pulse_reset();
        rst = 1'b0;
        load_req = 1'b0;
        compute_done = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        base_addr = b;
        cur_base  = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = ADDR_W'($urandom);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy: got %b expected 1", busy); end
        checks++; if (tile_idx !== TILE_W'(0)) begin failures++; $display("FAIL start_tile: got %0d expected 0", tile_idx); end
        checks++; if (w_ps !== 1'b0) begin failures++; $display("FAIL start_wps: got %b expected 0", w_ps); end
    endtask

    // One tile: optional idle, fetch, hold, release. Entered at a negedge in WAIT_REQ.
    task automatic do_tile(input int k, input int pre_idle, input int drop_at,
                           input int rst_at, input int hold_cycles);
        logic exp_rd, exp_wv, exp_ps;
        logic [ADDR_W-1:0] ea;
        logic [DW-1:0]     ed;
        load_req = 1'b0;
        for (int i = 0; i < pre_idle; i++) begin
            @(negedge clk);
            checks++; if (mem_rd_en !== 1'b0 || w_ps !== 1'b0) begin
                failures++; $display("FAIL wait_idle t%0d: rd_en=%b w_ps=%b expected 0/0", k, mem_rd_en, w_ps);
            end
        end
        load_req = 1'b1;
        for (int c = 0; c <= int'(ARRAY_N) + 1; c++) begin
            @(negedge clk);
            exp_rd = (c < int'(ARRAY_N));
            exp_wv = (c >= 1) && (c <= int'(ARRAY_N));
            exp_ps = (c == int'(ARRAY_N) + 1);
            checks++; if (mem_rd_en !== exp_rd) begin
                failures++; $display("FAIL rd_en t%0d c%0d: got %b expected %b", k, c, mem_rd_en, exp_rd);
            end
            if (exp_rd) begin
                ea = addr_of(k, c);
                checks++; if (mem_addr !== ea) begin
                    failures++; $display("FAIL addr t%0d c%0d: got %03h expected %03h", k, c, mem_addr, ea);
                end
            end
            checks++; if (w_valid !== exp_wv) begin
                failures++; $display("FAIL w_valid t%0d c%0d: got %b expected %b", k, c, w_valid, exp_wv);
            end
            if (exp_wv) begin
                ed = mem[addr_of(k, c - 1)];
                checks++; if (w_row !== ROW_W'(c - 1)) begin
                    failures++; $display("FAIL w_row t%0d c%0d: got %0d expected %0d", k, c, w_row, c - 1);
                end
                checks++; if (w_data !== ed) begin
                    failures++; $display("FAIL w_data t%0d c%0d: got %h expected %h", k, c, w_data, ed);
                end
            end
            checks++; if (w_ps !== exp_ps) begin
                failures++; $display("FAIL w_ps t%0d c%0d: got %b expected %b", k, c, w_ps, exp_ps);
            end
            if (c == drop_at) load_req = 1'b0;
            if (c == rst_at) begin
                rst = 1'b0;
                #1;
                checks++; if ({mem_rd_en, w_valid, w_ps, busy, done} !== 5'b0 || mem_addr !== '0 ||
                              w_row !== '0 || w_data !== '0 || tile_idx !== '0) begin
                    failures++; $display("FAIL abort_zero: rd=%b wv=%b ps=%b busy=%b done=%b addr=%h row=%0d tile=%0d expected all 0",
                                         mem_rd_en, w_valid, w_ps, busy, done, mem_addr, w_row, tile_idx);
                end
                load_req = 1'b0;
                @(negedge clk);
                checks++; if (w_valid !== 1'b0) begin
                    failures++; $display("FAIL abort_wvalid: got %b expected 0", w_valid);
                end
                rst = 1'b1;
                @(negedge clk);
                return;
            end
        end
        load_req = 1'b1;
        for (int h = 0; h < hold_cycles; h++) begin
            @(negedge clk);
            checks++; if (mem_rd_en !== 1'b0 || w_ps !== 1'b1) begin
                failures++; $display("FAIL hold t%0d h%0d: rd_en=%b w_ps=%b expected 0/1", k, h, mem_rd_en, w_ps);
            end
        end
        compute_done = 1'b1;
        @(negedge clk);
        compute_done = 1'b0;
        checks++; if (w_ps !== 1'b0) begin failures++; $display("FAIL release_wps t%0d: got %b expected 0", k, w_ps); end
        checks++; if (tile_idx !== TILE_W'(k + 1)) begin
            failures++; $display("FAIL tile_idx t%0d: got %0d expected %0d", k, tile_idx, k + 1);
        end
        checks++; if (done !== (k + 1 == int'(NUM_TILES)) || busy !== (k + 1 != int'(NUM_TILES))) begin
            failures++; $display("FAIL done_busy t%0d: done=%b busy=%b", k, done, busy);
        end
        if (k + 1 == int'(NUM_TILES)) load_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({mem_rd_en, w_valid, w_ps, busy, done} !== 5'b0 || mem_addr !== '0 ||
                      w_row !== '0 || w_data !== '0 || tile_idx !== '0) begin
            failures++; $display("FAIL reset_outputs: rd=%b wv=%b ps=%b busy=%b done=%b expected all 0",
                                 mem_rd_en, w_valid, w_ps, busy, done);
        end
`ifdef WTL_PROTOCOL_CHECK_EN
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        pulse_reset();
        do_start(12'h100);
        do_tile(0, 0, -1, -1, 4);
    endtask

    task automatic test_full_job();
        int r0, d0;
        pulse_reset();
        do_start(ADDR_W'($urandom));
        r0 = ps_rises;
        d0 = done_pulses;
        for (int k = 0; k < int'(NUM_TILES); k++) begin
            do_tile(k, int'($urandom_range(0, 3)), -1, -1, 4);
        end
        load_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (mem_rd_en !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL idle_after_job: rd_en=%b busy=%b expected 0/0", mem_rd_en, busy);
            end
        end
        load_req = 1'b0;
        #1;
        checks++; if (ps_rises - r0 !== 32) begin failures++; $display("FAIL wps_rises: got %0d expected 32", ps_rises - r0); end
        checks++; if (done_pulses - d0 !== 1) begin failures++; $display("FAIL done_pulses: got %0d expected 1", done_pulses - d0); end
        checks++; if (tile_idx !== TILE_W'(NUM_TILES)) begin
            failures++; $display("FAIL final_tile_idx: got %0d expected %0d", tile_idx, NUM_TILES);
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        do_start(12'hFF8);
        do_tile(0, 0, -1, -1, 1);
        do_tile(1, 1, -1, -1, 2);
    endtask

    task automatic test_drop();
        pulse_reset();
        do_start(ADDR_W'($urandom));
        do_tile(0, 1, 2, -1, 3);
        do_tile(1, 0, 0, -1, 1);
    endtask

    task automatic test_mid_reset();
        pulse_reset();
        do_start(ADDR_W'($urandom));
        do_tile(0, 0, -1, -1, 1);
        do_tile(1, 0, -1, 4, 0);
        do_start(ADDR_W'($urandom));
        do_tile(0, 0, -1, -1, 2);
    endtask

    task automatic test_start_ignored();
        pulse_reset();
        do_start(12'h200);
        base_addr = 12'h700;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || tile_idx !== TILE_W'(0)) begin
            failures++; $display("FAIL start_busy_ignored: busy=%b tile=%0d expected 1/0", busy, tile_idx);
        end
        do_tile(0, 0, -1, -1, 2);
    endtask

    task automatic test_protocol();
        pulse_reset();
        do_start(ADDR_W'($urandom));
`ifdef WTL_PROTOCOL_CHECK_EN
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL proto_pre: got %b expected 0", proto_err); end
`endif
        compute_done = 1'b1;
        @(negedge clk);
        compute_done = 1'b0;
`ifdef WTL_PROTOCOL_CHECK_EN
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_set: got %b expected 1", proto_err); end
`endif
        checks++; if (tile_idx !== TILE_W'(0) || w_ps !== 1'b0 || busy !== 1'b1 || mem_rd_en !== 1'b0) begin
            failures++; $display("FAIL stray_done: tile=%0d w_ps=%b busy=%b rd=%b expected 0/0/1/0", tile_idx, w_ps, busy, mem_rd_en);
        end
        do_tile(0, 0, -1, -1, 2);
`ifdef WTL_PROTOCOL_CHECK_EN
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end
`endif
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        base_addr    = '0;
        load_req     = 1'b0;
        compute_done = 1'b0;
        cur_base     = '0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = {$urandom, $urandom};
        test_reset();
        test_basic();
        test_full_job();
        test_wrap();
        test_drop();
        test_mid_reset();
        test_start_ignored();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_tile_loader.md
Name: weight_tile_loader

Overview:
Upstream feeder for the systolic-array control FSM. Streams weight tiles, ARRAY_N rows each, from the weight SRAM into the array's weight registers, one row per cycle. It answers the controller's load request (the controller's ctrl_out) with the weights-preloaded flag w_ps. After NUM_TILES tiles it signals job completion. It drives w_ps exactly as the controller's s0/s1/s2 handshake expects.

Parameters:
DATA_W, 8, bits per weight element
ARRAY_N, 8, array dimension; rows per tile and elements per row
NUM_TILES, 32, tiles per job; must equal the controller's tile count
ADDR_W, 12, weight SRAM row-address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle job start pulse
base_addr  in  ADDR_W  SRAM row address of tile 0; latched on accepted start
load_req  in  1  load request from controller (its ctrl_out)
compute_done  in  1  one-cycle pulse: array finished with the current tile
mem_rd_en  out  1  SRAM read strobe
mem_addr  out  ADDR_W  SRAM row address
mem_rdata  in  ARRAY_N*DATA_W  SRAM data, valid exactly 1 cycle after mem_rd_en
w_data  out  ARRAY_N*DATA_W  weight row to the array
w_valid  out  1  w_data/w_row valid this cycle
w_row  out  $clog2(ARRAY_N)  destination row index
w_ps  out  1  weights preloaded; to controller
tile_idx  out  $clog2(NUM_TILES+1)  tiles completed in the current job
busy  out  1  job in progress
done  out  1  one-cycle pulse when the last tile is released

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-operation aborts immediately. No partial state survives, and no w_valid is produced from an in-flight read.
- All outputs are registered.
- States: IDLE, WAIT_REQ, FETCH, HOLD.
- IDLE:
  - start=1: latch base_addr, clear tile_idx, busy<=1, go to WAIT_REQ.
  - start in any other state is ignored.
- WAIT_REQ: load_req=1 goes to FETCH. w_ps=0.
- FETCH, entered at cycle T:
  - mem_rd_en=1 on cycles T..T+ARRAY_N-1.
  - mem_addr = base + tile_idx*ARRAY_N + row, with row 0..ARRAY_N-1. Address arithmetic wraps modulo 2^ADDR_W.
  - w_valid=1 on cycles T+1..T+ARRAY_N. w_data = mem_rdata, w_row = row of the corresponding read.
  - Go to HOLD once the last read is issued. w_ps rises at cycle T+ARRAY_N+1, the cycle after the last w_valid.
  - load_req dropping during FETCH is ignored; the fetch always completes.
- HOLD: w_ps=1.
  - compute_done=1: w_ps<=0 and tile_idx<=tile_idx+1.
    - If tile_idx+1==NUM_TILES: done pulses 1 cycle, busy<=0, go to IDLE.
    - Otherwise go to WAIT_REQ.
  - load_req held high through HOLD does not trigger a new fetch.
- compute_done outside HOLD: ignored.
- load_req and compute_done high in the same HOLD cycle: compute_done wins. The next fetch starts from WAIT_REQ on the following cycle if load_req is still high.
- Total latency from load_req accepted to w_ps=1: ARRAY_N+2 cycles.

Optional Feature:
Macro WTL_PROTOCOL_CHECK_EN.
- Defined:
  - Adds output proto_err (1 bit, sticky, reset 0).
  - Sets on: compute_done outside HOLD; start while busy; load_req low during WAIT_REQ for more than 1024 consecutive cycles (watchdog).
  - Cleared only by rst.
- Undefined: the port and logic are absent. The illegal events above are silently ignored as specified in Behaviour.

Test Plan:
- Reset, then start with base_addr=0x100, then load_req=1 -> mem_rd_en for 8 cycles at addresses 0x100..0x107; w_valid for 8 cycles with w_row 0..7 matching mem_rdata; w_ps=1 exactly 10 cycles after load_req was sampled.
- Full job of 32 tiles, with compute_done 5 cycles after each w_ps rise -> tile k reads from base+8k; tile_idx counts to 32; done pulses once; busy falls; w_ps toggles 32 times.
- base_addr=0xFF8, tile 1 -> addresses wrap to 0x000..0x007.
- load_req deasserted 2 cycles into FETCH -> all 8 rows are still delivered and w_ps rises.
- rst asserted at row 4 of FETCH -> all outputs 0 immediately; a subsequent start restarts at tile 0, row 0.
- WTL_PROTOCOL_CHECK_EN defined, compute_done pulsed in WAIT_REQ -> proto_err=1 next cycle and it stays 1; with the macro undefined, there is no state change.
